// File: rtl/mcss_pkg.sv
// Shared constants and types for the MCSS issue controller and its result FIFO.
package mcss_pkg;

  localparam int WORD_W    = 32;
  localparam int TAG_COL_W = 16;

  // Most-negative signed 32-bit value; the running frame maximum starts here.
  localparam logic signed [WORD_W-1:0] MIN_S32 = 32'sh8000_0000;

  // Engine latency: one register per reduction-tree level plus the input register.
  function automatic int mcss_lat(input int img_rows);
    return $clog2(img_rows) + 1;
  endfunction

  typedef struct packed {
    logic [TAG_COL_W-1:0] col;
    logic                 last;
  } res_tag_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    res_tag_t          tag;
  } res_entry_t;

endpackage

// File: rtl/mcss_res_fifo.sv
// Synchronous result FIFO with occupancy count, same-cycle push/pop (legal even
// when full) and an overflow strobe for a push that finds no room.
module mcss_res_fifo
  import mcss_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  res_entry_t                 wdata,
  input  logic                       pop,
  output res_entry_t                 rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  res_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Pointer wrap that also works for depths that are not a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && (count != '0);
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && !do_push;
  assign rdata    = mem[rd_ptr];

  // Payload storage write.
  // NOTE: the payload array has no reset; pointers and count decide which entries are live and the reader gates data with valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy update.
  // NOTE: sequential state uses nonblocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/mcss_sched.sv
// Issue controller for the pipelined MCSS reduction engine: credit-based issue,
// tag pipeline aligned to engine latency, in-order result FIFO, frame maximum.
module mcss_sched
  import mcss_pkg::*;
#(
  parameter int IMG_ROWS   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int COL_W      = TAG_COL_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IMG_ROWS*WORD_W-1:0] in_data,
  input  logic                       in_last,
  output logic                       eng_en,
  output logic [IMG_ROWS*WORD_W-1:0] eng_arr,
  input  logic                       eng_valid,
  input  logic                       eng_empty,
  input  logic [WORD_W-1:0]          eng_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_W-1:0]          out_data,
  output logic [COL_W-1:0]           out_col,
  output logic                       out_last,
  output logic [WORD_W-1:0]          frame_max,
  output logic                       frame_max_valid,
  output logic                       busy,
  output logic                       err
);

  localparam int LAT   = mcss_lat(IMG_ROWS);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(LAT + 1);
  localparam int SUM_W = $clog2(FIFO_DEPTH + LAT + 1) + 1;

  typedef struct packed {
    logic     valid;
    res_tag_t tag;
  } slot_t;

  logic                       accept;
  logic                       pop;
  logic                       stray;
  logic                       push;
  logic [INF_W-1:0]           inflight;
  logic [CNT_W-1:0]           fifo_count;
  logic [SUM_W-1:0]           credit_used;
  logic [COL_W-1:0]           col_cnt;
  logic [IMG_ROWS*WORD_W-1:0] arr_q;
  slot_t                      tag_pipe [LAT];
  slot_t                      tag_out;
  res_entry_t                 fifo_wdata;
  res_entry_t                 fifo_rdata;
  logic                       fifo_overflow;
  logic signed [WORD_W-1:0]   running_max;
  logic signed [WORD_W-1:0]   pop_max;

  // Credits: everything buffered or still inside the engine, less the entry leaving now.
  assign pop         = out_valid && out_ready;
  assign credit_used = SUM_W'(fifo_count) + SUM_W'(inflight) - SUM_W'(pop);
  assign in_ready    = !rst && (credit_used < SUM_W'(FIFO_DEPTH));
  assign accept      = in_valid && in_ready;

  // The engine registers eng_arr itself, so the column is passed through on the accept cycle.
  assign eng_en  = accept;
  assign eng_arr = accept ? in_data : arr_q;

  // A result with nothing in flight has no owner and is dropped.
  assign stray   = eng_valid && (inflight == '0);
  assign push    = eng_valid && !stray;
  assign tag_out = tag_pipe[LAT-1];

  assign busy = (inflight != '0) || (fifo_count != '0) || !eng_empty;

  // Hold the last issued column so eng_arr is stable between issues.
  always_ff @(posedge clk) begin
    if (rst)         arr_q <= '0;
    else if (accept) arr_q <= in_data;
  end

  // Count columns inside the engine: up on issue, down on an owned result.
  always_ff @(posedge clk) begin
    if (rst) inflight <= '0;
    else     inflight <= inflight + INF_W'(accept) - INF_W'(push);
  end

  // Tag shift register, LAT deep, so each tag emerges together with its eng_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0].valid   <= accept;
      tag_pipe[0].tag.col <= TAG_COL_W'(col_cnt);
      tag_pipe[0].tag.last <= in_last;
      for (int i = 1; i < LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  // Column index within the frame; restarts after the frame's last column.
  always_ff @(posedge clk) begin
    if (rst)         col_cnt <= '0;
    else if (accept) col_cnt <= in_last ? '0 : col_cnt + 1'b1;
  end

  // Assemble the FIFO entry from the engine result and its tag.
  always_comb begin
    // NOTE: default the whole struct first so no path through this block can infer a latch.
    fifo_wdata      = '0;
    fifo_wdata.data = eng_result;
    fifo_wdata.tag  = tag_out.tag;
  end

  mcss_res_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .wdata    (fifo_wdata),
    .pop      (pop),
    .rdata    (fifo_rdata),
    .count    (fifo_count),
    .overflow (fifo_overflow)
  );

  // Head of the FIFO, forced to zero when empty so stale payload never shows.
  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? fifo_rdata.data : '0;
  assign out_col   = out_valid ? COL_W'(fifo_rdata.tag.col) : '0;
  assign out_last  = out_valid && fifo_rdata.tag.last;

  // Sticky protocol error: orphan result, tag misalignment, or FIFO overflow.
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if (stray || (tag_out.valid != eng_valid) || fifo_overflow) err <= 1'b1;
  end

  assign pop_max = ($signed(out_data) > running_max) ? $signed(out_data) : running_max;

  // Running maximum over popped results; published and restarted on the frame's last pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      running_max     <= MIN_S32;
      frame_max       <= '0;
      frame_max_valid <= 1'b0;
    end else begin
      frame_max_valid <= pop && out_last;
      if (pop) begin
        if (out_last) begin
          frame_max   <= pop_max;
          running_max <= MIN_S32;
        end else begin
          running_max <= pop_max;
        end
      end
    end
  end

endmodule
